path_executor: RTL and testbench

PATH_EXECUTOR -- requirements
Module: path_executor

---
 rtl/path_executor.sv | 193 +++++++++++++++++++
 tb/tb_path_executor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/path_executor.sv
`default_nettype none
// ============================================================================
// Module      : path_executor
// Description : Steps a robot through a planner-supplied node path, one
//               acknowledged segment at a time, with abort and ack timeout.
// Revision    : 1.0
// ============================================================================
module path_executor #(
  parameter int MAX_NODES   = 10,
  parameter int NODE_W      = 5,
  parameter int SENTINEL    = 27,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        path_done,
  input  logic [MAX_NODES*NODE_W-1:0] final_path,
  input  logic                        node_reached,
  input  logic                        abort,
  output logic [NODE_W-1:0]           cur_node,
  output logic [NODE_W-1:0]           next_node,
  output logic                        node_valid,
  output logic [3:0]                  seg_index,
  output logic                        busy,
  output logic                        path_complete,
  output logic                        path_err
);

  localparam int LEN_W = $clog2(MAX_NODES + 1);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [NODE_W-1:0] SENT_V  = NODE_W'(SENTINEL);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [MAX_NODES*NODE_W-1:0]   path_q, path_d;
  logic                          pd_prev_q;
  logic [NODE_W-1:0]             cur_node_q, cur_node_d;
  logic [NODE_W-1:0]             next_node_q, next_node_d;
  logic [3:0]                    seg_index_q, seg_index_d;
  logic                          node_valid_q, node_valid_d;
  logic                          busy_q, busy_d;
  logic                          path_complete_q, path_complete_d;
  logic                          path_err_q, path_err_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LEN_W-1:0]              len_q, len_d;

  logic                          pd_rise;
  logic [LEN_W-1:0]              path_len;
  logic                          len_found;
  logic [NODE_W-1:0]             slot_ahead;

  assign pd_rise = path_done & ~pd_prev_q;

  // Length = index of the first slot holding a code at or above the sentinel.
  always_comb begin
    path_len  = LEN_W'(MAX_NODES);
    len_found = 1'b0;
    for (int k = 0; k < MAX_NODES; k++) begin
      if (!len_found && (path_q[k*NODE_W +: NODE_W] >= SENT_V)) begin
        path_len  = LEN_W'(k);
        len_found = 1'b1;
      end
    end
  end

  // Target of the segment after the one being acknowledged.
  always_comb begin
    slot_ahead = '0;
    for (int k = 0; k < MAX_NODES; k++) begin
      if (k == int'(seg_index_q) + 2) begin
        slot_ahead = path_q[k*NODE_W +: NODE_W];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    path_d          = path_q;
    cur_node_d      = cur_node_q;
    next_node_d     = next_node_q;
    seg_index_d     = seg_index_q;
    cnt_d           = cnt_q;
    len_d           = len_q;
    path_complete_d = 1'b0;
    path_err_d      = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pd_rise) begin
            path_d  = final_path;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          len_d = path_len;
          cnt_d = '0;
          if (path_len == '0) begin
            path_err_d = 1'b1;
            state_d    = S_IDLE;
          end else if (path_len == LEN_W'(1)) begin
            cur_node_d      = path_q[NODE_W-1:0];
            path_complete_d = 1'b1;
            state_d         = S_DONE;
          end else begin
            cur_node_d  = path_q[NODE_W-1:0];
            next_node_d = path_q[2*NODE_W-1:NODE_W];
            seg_index_d = '0;
            state_d     = S_RUN;
          end
        end
        S_RUN: begin
          // An acknowledgment in the timeout cycle still wins.
          if (node_reached) begin
            cur_node_d  = next_node_q;
            seg_index_d = seg_index_q + 4'd1;
            cnt_d       = '0;
            if (int'(seg_index_q) + 2 == int'(len_q)) begin
              path_complete_d = 1'b1;
              state_d         = S_DONE;
            end else begin
              next_node_d = slot_ahead;
              state_d     = S_GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            path_err_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP:   state_d = S_RUN;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    node_valid_d = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      path_q          <= '0;
      pd_prev_q       <= 1'b1;
      cur_node_q      <= '0;
      next_node_q     <= '0;
      seg_index_q     <= '0;
      node_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      path_complete_q <= 1'b0;
      path_err_q      <= 1'b0;
      cnt_q           <= '0;
      len_q           <= '0;
    end else begin
      state_q         <= state_d;
      path_q          <= path_d;
      pd_prev_q       <= path_done;
      cur_node_q      <= cur_node_d;
      next_node_q     <= next_node_d;
      seg_index_q     <= seg_index_d;
      node_valid_q    <= node_valid_d;
      busy_q          <= busy_d;
      path_complete_q <= path_complete_d;
      path_err_q      <= path_err_d;
      cnt_q           <= cnt_d;
      len_q           <= len_d;
    end
  end

  assign cur_node      = cur_node_q;
  assign next_node     = next_node_q;
  assign node_valid    = node_valid_q;
  assign seg_index     = seg_index_q;
  assign busy          = busy_q;
  assign path_complete = path_complete_q;
  assign path_err      = path_err_q;

endmodule
`default_nettype wire

// File: tb/tb_path_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_path_executor
// Description : Directed table-driven bench for path_executor (ACK_TIMEOUT=8).
// Revision    : 1.0
// ============================================================================
module tb_path_executor;

  logic        clk = 1'b0;
  logic        rst;
  logic        path_done;
  logic [49:0] final_path;
  logic        node_reached;
  logic        abort;
  logic [4:0]  cur_node;
  logic [4:0]  next_node;
  logic        node_valid;
  logic [3:0]  seg_index;
  logic        busy;
  logic        path_complete;
  logic        path_err;

  int checks = 0;
  int errors = 0;
  int obs_nv, obs_cmp, obs_err, obs_end, busy_seen;

  typedef struct {
    logic [9:0][4:0] slots;
    int delay;
    int e_cur, e_seg, e_next, e_cmp, e_err, e_nv;
  } vec_t;

  vec_t vecs[8];

  path_executor #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .path_done(path_done), .final_path(final_path),
    .node_reached(node_reached), .abort(abort), .cur_node(cur_node),
    .next_node(next_node), .node_valid(node_valid), .seg_index(seg_index),
    .busy(busy), .path_complete(path_complete), .path_err(path_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0][4:0] pk(input int s0, input int s1, input int s2);
    logic [9:0][4:0] p;
    p    = {10{5'd27}};
    p[0] = 5'(s0);
    p[1] = 5'(s1);
    p[2] = 5'(s2);
    return p;
  endfunction

  function automatic logic [9:0][4:0] full_path();
    logic [9:0][4:0] p;
    for (int k = 0; k < 10; k++) p[k] = 5'(k + 1);
    return p;
  endfunction

  // delay < 0 means never acknowledge; toggle re-pulses path_done mid-run.
  task automatic run_path(input logic [49:0] p, input int delay, input bit toggle);
    int w;
    bit started;
    final_path = p;
    path_done  = 1'b0;
    tick();
    path_done = 1'b1;
    obs_nv = 0; obs_cmp = 0; obs_err = 0; obs_end = 0;
    w = 0; started = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (node_valid)    obs_nv++;
      if (path_complete) obs_cmp++;
      if (path_err)      obs_err++;
      if (busy) started = 1;
      if (toggle && c == 3) path_done = 1'b0;
      if (toggle && c == 4) begin
        path_done  = 1'b1;
        final_path = '0;
      end
      node_reached = (node_valid && delay >= 0 && w == delay);
      w = node_valid ? w + 1 : 0;
      if (started && !busy) begin
        obs_end = 1;
        break;
      end
    end
    node_reached = 1'b0;
    path_done    = 1'b0;
    check("path_terminates", obs_end, 1);
  endtask

  task automatic wait_nv(input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (node_valid) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cur"},  cur_node, 0);
    check({tag, "_next"}, next_node, 0);
    check({tag, "_seg"},  seg_index, 0);
    check({tag, "_nv"},   node_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmp"},  path_complete, 0);
    check({tag, "_err"},  path_err, 0);
  endtask

  initial begin
    rst = 1'b0; path_done = 1'b1; final_path = '0; node_reached = 1'b0; abort = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("init");
    tick();
    rst = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      tick();
      if (busy) busy_seen++;
    end
    check("level_high_after_reset", busy_seen, 0);

    //                 slots            delay cur seg next cmp err nv
    vecs[0] = '{pk(0, 3, 8),     0,    8,  2,  8,   1,  0,  2};
    vecs[1] = '{pk(27, 27, 27),  0,    8,  2,  8,   0,  1,  0};
    vecs[2] = '{pk(11, 27, 27),  0,    11, 2,  8,   1,  0,  0};
    vecs[3] = '{full_path(),     2,    10, 9,  10,  1,  0,  27};
    vecs[4] = '{pk(5, 30, 27),   0,    5,  9,  10,  1,  0,  0};
    vecs[5] = '{pk(4, 26, 27),   1,    26, 1,  26,  1,  0,  2};
    vecs[6] = '{pk(7, 9, 27),    -1,   7,  0,  9,   0,  1,  8};
    vecs[7] = '{pk(2, 6, 27),    7,    6,  1,  6,   1,  0,  8};

    for (int i = 0; i < 8; i++) begin
      run_path(vecs[i].slots, vecs[i].delay, 1'b0);
      check($sformatf("v%0d_cur", i),  cur_node,  vecs[i].e_cur);
      check($sformatf("v%0d_seg", i),  seg_index, vecs[i].e_seg);
      check($sformatf("v%0d_next", i), next_node, vecs[i].e_next);
      check($sformatf("v%0d_cmp", i),  obs_cmp,   vecs[i].e_cmp);
      check($sformatf("v%0d_err", i),  obs_err,   vecs[i].e_err);
      check($sformatf("v%0d_nv", i),   obs_nv,    vecs[i].e_nv);
    end

    // New path_done edge during RUN must not disturb the latched path.
    run_path(full_path(), 0, 1'b1);
    check("toggle_cur", cur_node, 10);
    check("toggle_seg", seg_index, 9);
    check("toggle_cmp", obs_cmp, 1);
    busy_seen = 0;
    repeat (4) begin
      tick();
      if (busy) busy_seen++;
    end
    check("toggle_no_restart", busy_seen, 0);

    // Abort together with node_reached in RUN.
    final_path = pk(0, 3, 8);
    path_done  = 1'b0;
    tick();
    path_done = 1'b1;
    wait_nv("abort_reach_run");
    abort = 1'b1; node_reached = 1'b1;
    tick();
    abort = 1'b0; node_reached = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_nv", node_valid, 0);
    check("abort_cur", cur_node, 0);
    check("abort_seg", seg_index, 0);
    check("abort_cmp", path_complete, 0);
    check("abort_err", path_err, 0);
    tick();
    check("abort_after_busy", busy, 0);
    check("abort_after_pulses", {30'd0, path_complete, path_err}, 0);

    // Asynchronous reset while in RUN, path_done held high across release.
    path_done = 1'b0;
    tick();
    path_done = 1'b1;
    wait_nv("rst_reach_run");
    #2 rst = 1'b1;
    #1 check_reset("midrun");
    tick();
    #2 rst = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      tick();
      if (busy) busy_seen++;
    end
    check("rst_no_restart", busy_seen, 0);
    run_path(pk(0, 3, 8), 0, 1'b0);
    check("rst_recover_cur", cur_node, 8);
    check("rst_recover_cmp", obs_cmp, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
